cache_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 8-bit data cache.
- Requester 0 is instruction fetch and requester 1 is load/store; both share the one cache port.
- Grants one request at a time, round-robin on contention, drives the cache ce/rw/addr/data strobe, waits for cache odv, returns read data and a one-cycle done pulse to the winner.
- A watchdog counter bounds the wait for odv and flags an error if it expires.

---
 rtl/cache_port_arbiter_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/cache_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_cache_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// rtl/cache_port_arbiter_pkg.sv - shared state encoding and direction constants for the cache port arbiter
package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Direction encoding shared with the cache and RAM wrappers.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with registered last-grant on accept
module rr_arbiter2 (
    input  logic clk,
    input  logic clr,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_valid    = req0 | req1;
        gnt_id       = 1'b0;
        last_grant_d = last_grant_q;
        if (req0 && req1) begin
            gnt_id = ~last_grant_q;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
        if (accept) begin
            last_grant_d = gnt_id;
        end
    end

    // Resetting to 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - arbitrates two requesters onto one cache port with an odv watchdog
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int timeout = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req0,
    input  logic               rw0,
    input  logic [a_width-1:0] addr0,
    input  logic [d_width-1:0] wdata0,
    output logic [d_width-1:0] rdata0,
    output logic               done0,
    input  logic               req1,
    input  logic               rw1,
    input  logic [a_width-1:0] addr1,
    input  logic [d_width-1:0] wdata1,
    output logic [d_width-1:0] rdata1,
    output logic               done1,
    output logic               err,
    output logic [a_width-1:0] c_addr,
    output logic [d_width-1:0] c_wdata,
    output logic               c_rw,
    output logic               c_ce,
    input  logic [d_width-1:0] c_rdata,
    input  logic               c_odv
);

    localparam int wd_w = $clog2(timeout + 1);
    localparam logic [wd_w-1:0] wd_limit = wd_w'(timeout);

    state_e             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               rw_q, rw_d;
    logic [a_width-1:0] addr_q, addr_d;
    logic [d_width-1:0] wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [wd_w-1:0]    wd_q, wd_d;
    logic [wd_w-1:0]    wd_next;
    logic [d_width-1:0] rdata0_q, rdata0_d;
    logic [d_width-1:0] rdata1_q, rdata1_d;

    logic arb_valid;
    logic arb_id;
    logic accept;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .clr       (clr),
        .req0      (req0),
        .req1      (req1),
        .accept    (accept),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    assign wd_next = wd_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        wd_d     = wd_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        accept   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    accept  = 1'b1;
                    gnt_d   = arb_id;
                    rw_d    = arb_id ? rw1 : rw0;
                    addr_d  = arb_id ? addr1 : addr0;
                    wdata_d = arb_id ? wdata1 : wdata0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // odv takes priority over an expiring watchdog in the same cycle.
                if (c_odv) begin
                    if (rw_q == RW_READ) begin
                        if (gnt_q) begin
                            rdata1_d = c_rdata;
                        end else begin
                            rdata0_d = c_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_next;
                    if (wd_next == wd_limit) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Address, direction and data stay on the port from ISSUE through WAIT; ce strobes in ISSUE only.
    assign c_ce    = (state_q == ST_ISSUE);
    assign c_addr  = addr_q;
    assign c_rw    = rw_q;
    assign c_wdata = wdata_q;
    assign done0   = (state_q == ST_DONE) && !gnt_q;
    assign done1   = (state_q == ST_DONE) && gnt_q;
    assign err     = (state_q == ST_DONE) && err_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - self-checking bench for cache_port_arbiter
module tb_cache_port_arbiter;

    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [7:0] rdata0, rdata1, c_addr, c_wdata;
    logic       done0, done1, err, c_rw, c_ce;
    logic [7:0] c_rdata = '0;
    logic       c_odv = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    cache_port_arbiter #(.d_width(8), .a_width(8), .timeout(TIMEOUT)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .done0(done0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .done1(done1),
        .err(err), .c_addr(c_addr), .c_wdata(c_wdata), .c_rw(c_rw), .c_ce(c_ce),
        .c_rdata(c_rdata), .c_odv(c_odv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] cache_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5C);
    endfunction

    // Cache stand-in: mode 0 = manual, 1 = odv in the cycle after ce, 2 = never responds.
    int         cache_mode = 1;
    logic       ce_seen = 1'b0;
    logic [7:0] ce_addr_seen = '0;

    always @(negedge clk) begin
        ce_seen = c_ce;
        ce_addr_seen = c_addr;
    end

    always @(posedge clk) begin
        #1;
        if (cache_mode != 0) begin
            c_odv = 1'b0;
            if (cache_mode == 1 && ce_seen) begin
                c_odv = 1'b1;
                c_rdata = cache_val(ce_addr_seen);
            end
        end
    end

    // Transaction-level model: one job at a time, each job walks issue -> wait -> complete.
    localparam int M_FREE = 0, M_ISSUING = 1, M_WAITING = 2, M_COMPLETE = 3;
    int         m_stage = M_FREE;
    int         m_who = 0;
    int         m_last = 1;
    int         m_waited = 0;
    bit         m_timed_out = 1'b0;
    bit         m_on = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0;
    logic       m_rw = 1'b0;
    logic [7:0] m_rdata [2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_on = 1'b1;
            m_stage = M_FREE;
            m_last = 1;
            m_timed_out = 1'b0;
            m_addr = '0; m_wdata = '0; m_rw = 1'b0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
            case (m_stage)
                M_FREE: if (req0 || req1) begin
                    if (req0 && req1) m_who = 1 - m_last;
                    else m_who = req1 ? 1 : 0;
                    m_last = m_who;
                    m_addr = m_who == 1 ? addr1 : addr0;
                    m_rw = m_who == 1 ? rw1 : rw0;
                    m_wdata = m_who == 1 ? wdata1 : wdata0;
                    m_timed_out = 1'b0;
                    m_stage = M_ISSUING;
                end
                M_ISSUING: begin
                    m_waited = 0;
                    m_stage = M_WAITING;
                end
                M_WAITING: begin
                    m_waited++;
                    if (c_odv) begin
                        if (m_rw) m_rdata[m_who] = c_rdata;
                        m_stage = M_COMPLETE;
                    end else if (m_waited == TIMEOUT) begin
                        m_timed_out = 1'b1;
                        m_stage = M_COMPLETE;
                    end
                end
                default: m_stage = M_FREE;
            endcase
        end
    end

    int   ce_count = 0;
    int   done_count = 0;
    int   ce_cyc = 0;
    logic ce_rw_seen = 1'b0;
    logic [7:0] ce_wdata_seen = '0, ce_addr_cap = '0;
    int   order[$];

    always @(negedge clk) begin
        if (m_on) begin
            chk("c_ce", 32'(c_ce), 32'(m_stage == M_ISSUING));
            chk("done0", 32'(done0), 32'(m_stage == M_COMPLETE && m_who == 0));
            chk("done1", 32'(done1), 32'(m_stage == M_COMPLETE && m_who == 1));
            chk("err", 32'(err), 32'(m_stage == M_COMPLETE && m_timed_out));
            chk("c_addr", 32'(c_addr), 32'(m_addr));
            chk("c_rw", 32'(c_rw), 32'(m_rw));
            chk("c_wdata", 32'(c_wdata), 32'(m_wdata));
            chk("rdata0", 32'(rdata0), 32'(m_rdata[0]));
            chk("rdata1", 32'(rdata1), 32'(m_rdata[1]));
            chk("both_done", 32'(done0 && done1), 32'd0);
            if (c_ce) begin
                ce_count++;
                ce_cyc = cyc;
                ce_addr_cap = c_addr;
                ce_rw_seen = c_rw;
                ce_wdata_seen = c_wdata;
            end
            if (done0) order.push_back(0);
            if (done1) order.push_back(1);
            if (done0 || done1) done_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done0 || done1) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_done no done pulse within %0d cycles", budget);
    endtask

    task automatic wait_ce(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (c_ce) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_ce no ce within %0d cycles", budget);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit ok;
        int t0, c0, d0;

        // Reset state
        do_reset();
        @(negedge clk); #1;
        chk("rst_c_ce", 32'(c_ce), 32'd0);
        chk("rst_done", 32'({done0, done1}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_c_addr", 32'(c_addr), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);

        // Single read by requester 0
        step();
        c0 = ce_count;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h10;
        t0 = cyc;
        wait_done(20, ok);
        chk("t1_latency", 32'(cyc - t0), 32'd3);
        chk("t1_done0", 32'(done0), 32'd1);
        chk("t1_rdata0", 32'(rdata0), 32'hA5);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_ce_cycles", 32'(ce_count - c0), 32'd1);
        chk("t1_ce_addr", 32'(ce_addr_cap), 32'h10);
        req0 = 1'b0;
        step();

        // Contention: both held for four transactions after reset
        do_reset();
        order.delete();
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h21;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h20;
        for (int n = 0; n < 4; n++) wait_done(20, ok);
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("t2_count", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            chk("t2_order0", 32'(order[0]), 32'd0);
            chk("t2_order1", 32'(order[1]), 32'd1);
            chk("t2_order2", 32'(order[2]), 32'd0);
            chk("t2_order3", 32'(order[3]), 32'd1);
        end
        chk("t2_rdata0", 32'(rdata0), 32'h7D);
        chk("t2_rdata1", 32'(rdata1), 32'h7C);

        // Write by requester 1 leaves rdata1 alone
        req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h3C; wdata1 = 8'h5A;
        wait_done(20, ok);
        req1 = 1'b0;
        chk("t3_ce_rw", 32'(ce_rw_seen), 32'd0);
        chk("t3_ce_wdata", 32'(ce_wdata_seen), 32'h5A);
        chk("t3_ce_addr", 32'(ce_addr_cap), 32'h3C);
        chk("t3_done1", 32'(done1), 32'd1);
        chk("t3_rdata1", 32'(rdata1), 32'h7C);
        step();

        // Watchdog expiry, then a normal transaction
        cache_mode = 2;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h44;
        wait_ce(10);
        t0 = ce_cyc;
        wait_done(60, ok);
        chk("t4_wait_cycles", 32'(cyc - t0), 32'd33);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_rdata0_kept", 32'(rdata0), 32'h7D);
        req0 = 1'b0;
        step();
        cache_mode = 1;
        req0 = 1'b1;
        wait_done(20, ok);
        chk("t4b_err", 32'(err), 32'd0);
        chk("t4b_rdata0", 32'(rdata0), 32'h18);
        req0 = 1'b0;
        step();

        // Reset in the middle of WAIT abandons the job
        cache_mode = 2;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h30;
        wait_ce(10);
        step();
        step();
        d0 = done_count;
        clr = 1'b1; req1 = 1'b0;
        step();
        @(negedge clk); #1;
        chk("t5_c_ce", 32'(c_ce), 32'd0);
        chk("t5_done", 32'({done0, done1}), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        clr = 1'b0;
        cache_mode = 1;
        repeat (5) step();
        chk("t5_no_done", 32'(done_count - d0), 32'd0);
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h01;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h02;
        wait_done(20, ok);
        chk("t5_first_winner", 32'(done0), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        // Stray odv while idle
        cache_mode = 0;
        d0 = done_count;
        c0 = ce_count;
        c_odv = 1'b1; c_rdata = 8'hFF;
        step();
        step();
        c_odv = 1'b0;
        repeat (4) step();
        chk("t6_no_done", 32'(done_count - d0), 32'd0);
        chk("t6_no_ce", 32'(ce_count - c0), 32'd0);
        chk("t6_rdata0", 32'(rdata0), 32'(cache_val(8'h01)));
        cache_mode = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
